// File: rtl/seg_wr_arbiter.sv
// seg_wr_arbiter: round-robin write arbiter between two requesters and an 8-digit display core
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous, active-low reset
//   req0/req1           write requests; data0/data1 digit values, sel0/sel1 digit indices
//   ack0/ack1           one-cycle completion pulse to the granted requester
//   clr_req/clr_done    clear-all request and one-cycle completion pulse
//   input_data/select/en  registered write bus to the display core
//   busy                high whenever the arbiter is not idle
// Optional clear sequencer: define SEG_WR_CLEAR_EN. Without it clr_req is ignored and clr_done is 0.
module seg_wr_arbiter #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    input  logic [2:0] sel0,
    input  logic [2:0] sel1,
    output logic       ack0,
    output logic       ack1,
    input  logic       clr_req,
    output logic       clr_done,
    output logic [3:0] input_data,
    output logic [2:0] select,
    output logic       en,
    output logic       busy
);
`ifdef SEG_WR_CLEAR_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CLR} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD} state_t;
`endif

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner;
    logic       last;
    logic       grant1;

    // req1 wins when alone, or in contention when requester 0 was granted last
    assign grant1 = req1 & (~req0 | ~last);

`ifdef SEG_WR_CLEAR_EN
    logic       pend;
    logic       clearing;
    logic [2:0] clr_cnt;
`else
    localparam logic clearing = 1'b0;
    logic unused_clr;
    assign unused_clr = clr_req;
    assign clr_done   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last       <= 1'b1;
            en         <= 1'b0;
            select     <= '0;
            input_data <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
`ifdef SEG_WR_CLEAR_EN
            pend       <= 1'b0;
            clearing   <= 1'b0;
            clr_cnt    <= '0;
            clr_done   <= 1'b0;
`endif
        end else begin
`ifdef SEG_WR_CLEAR_EN
            if (clr_req) pend <= 1'b1;
`endif
            case (state)
                IDLE: begin
`ifdef SEG_WR_CLEAR_EN
                    // a pending clear beats both requesters; a clr_req on this same edge stays pending
                    if (pend) begin
                        pend     <= clr_req;
                        clearing <= 1'b1;
                        clr_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= CLR;
                    end else
`endif
                    if (req0 || req1) begin
                        owner      <= grant1;
                        last       <= grant1;
                        input_data <= grant1 ? data1 : data0;
                        select     <= grant1 ? sel1 : sel0;
                        cnt        <= SETUP_LOAD;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
`ifdef SEG_WR_CLEAR_EN
                CLR: begin
                    input_data <= '0;
                    select     <= clr_cnt;
                    cnt        <= SETUP_LOAD;
                    state      <= SETUP;
                end
`endif
                SETUP: begin
                    if (cnt == '0) begin
                        en    <= 1'b1;
                        cnt   <= STROBE_LOAD;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        en    <= 1'b0;
                        ack0  <= !clearing && !owner;
                        ack1  <= !clearing && owner;
`ifdef SEG_WR_CLEAR_EN
                        clr_done <= clearing && clr_cnt == 3'd7;
`endif
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
`ifdef SEG_WR_CLEAR_EN
                    clr_done <= 1'b0;
                    if (clearing && clr_cnt != 3'd7) begin
                        clr_cnt <= clr_cnt + 3'd1;
                        state   <= CLR;
                    end else begin
                        clearing <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
                default: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_wr_arbiter.sv
// tb_seg_wr_arbiter: scoreboard bench for seg_wr_arbiter
// Ports: none; drives the DUT with directed and random traffic, a transaction-level
// model predicts every en strobe, ack and clr_done with its cycle number.
// Honours SEG_WR_CLEAR_EN to select the clear-sequencer scenario.
module tb_seg_wr_arbiter;
    localparam int S = 2;
    localparam int T = 1;
    localparam int P = S + T + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, clr_req = 1'b0;
    logic [3:0] data0 = '0, data1 = '0;
    logic [2:0] sel0 = '0, sel1 = '0;
    logic       ack0, ack1, clr_done, en, busy;
    logic [3:0] input_data;
    logic [2:0] select;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int kind;
        int cyc;
        int sel;
        int dat;
    } ev_t;
    ev_t exp_q[$];

    int last_id = 1;
    int next_free = 0;
    int m_w;
    bit m_started;
`ifdef SEG_WR_CLEAR_EN
    bit pend = 1'b0;
`endif

    ev_t        mon_e;
    logic [3:0] mon_sig;
    bit         mon_ok;

    seg_wr_arbiter #(.SETUP_CYC(S), .STROBE_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .sel0(sel0), .sel1(sel1),
        .ack0(ack0), .ack1(ack1),
        .clr_req(clr_req), .clr_done(clr_done),
        .input_data(input_data), .select(select),
        .en(en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic result(string name, bit ok, string act, string req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %s, required %s", name, act, req);
        end
    endtask

    function automatic void push(int k, int c, int s, int d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.sel  = s;
        e.dat  = d;
        exp_q.push_back(e);
    endfunction

    // Reference model: event kinds 0=en strobe, 1=ack0, 2=ack1, 3=clr_done.
    // cyc labels the cycle that follows each rising edge.
    always @(posedge clk) begin
        cyc++;
        m_started = 1'b0;
        if (!rst) begin
            last_id   = 1;
            next_free = cyc + 1;
`ifdef SEG_WR_CLEAR_EN
            pend = 1'b0;
`endif
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= cyc) void'(exp_q.pop_back());
        end else begin
`ifdef SEG_WR_CLEAR_EN
            if (cyc >= next_free && pend) begin
                for (int k = 0; k < 8; k++) begin
                    for (int j = 0; j < T; j++) push(0, cyc + k*P + 1 + S + j, k, 0);
                    if (k == 7) push(3, cyc + k*P + 1 + S + T, 0, 0);
                end
                next_free = cyc + 8*P + 1;
                m_started = 1'b1;
            end
            pend = clr_req || (pend && !m_started);
`endif
            if (!m_started && cyc >= next_free && (req0 || req1)) begin
                m_w = (req0 && req1) ? 1 - last_id : (req1 ? 1 : 0);
                last_id = m_w;
                for (int j = 0; j < T; j++)
                    push(0, cyc + S + j, m_w != 0 ? int'(sel1) : int'(sel0), m_w != 0 ? int'(data1) : int'(data0));
                push(1 + m_w, cyc + S + T, 0, 0);
                next_free = cyc + S + T + 2;
            end
        end
    end

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            result("missed_event", mon_e.cyc >= cyc, $sformatf("nothing by cyc %0d", cyc),
                   $sformatf("kind %0d at cyc %0d", mon_e.kind, mon_e.cyc));
        end
        if (ack0 || ack1)
            result("ack_exclusive", !(ack0 && ack1), $sformatf("ack0=%0b ack1=%0b", ack0, ack1), "at most one");
        mon_sig = {clr_done, ack1, ack0, en};
        for (int k = 0; k < 4; k++) begin
            if (mon_sig[k]) begin
                mon_e.kind = -1; mon_e.cyc = -1; mon_e.sel = -1; mon_e.dat = -1;
                mon_ok = exp_q.size() != 0;
                if (mon_ok) begin
                    mon_e  = exp_q.pop_front();
                    mon_ok = mon_e.kind == k && mon_e.cyc == cyc &&
                             (k != 0 || (mon_e.sel == int'(select) && mon_e.dat == int'(input_data)));
                end
                result("event", mon_ok,
                       $sformatf("kind %0d cyc %0d sel %0d data %0h", k, cyc, select, input_data),
                       $sformatf("kind %0d cyc %0d sel %0d data %0h", mon_e.kind, mon_e.cyc, mon_e.sel, mon_e.dat));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; clr_req = 1'b0;
        repeat (2) @(negedge clk);
        result("reset_outputs", {en, ack0, ack1, busy, clr_done, select, input_data} == '0,
               $sformatf("en=%0b ack=%0b%0b busy=%0b clr_done=%0b sel=%0d data=%0h",
                         en, ack0, ack1, busy, clr_done, select, input_data), "all zero");
        rst = 1'b1;
    endtask

    int c0, n, t0, t1, done_at;
    int ids[8], ts[8], es[16], ed[16];
    bit got1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        // single write from requester 0
        do_reset();
        req0 = 1'b1; data0 = 4'h5; sel0 = 3'd2;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            result("single_select", select == 3'd2 && input_data == 4'h5,
                   $sformatf("sel %0d data %0h", select, input_data), "sel 2 data 5");
            result("single_en", en == (i == 3), $sformatf("en %0b in cycle %0d", en, i), $sformatf("%0b", i == 3));
            result("single_ack", ack0 == (i == 4) && !ack1, $sformatf("ack0 %0b ack1 %0b in cycle %0d", ack0, ack1, i),
                   $sformatf("ack0 %0b ack1 0", i == 4));
            if (i == 4) req0 = 1'b0;
        end

        // continuous contention alternates grants
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 4'h1; data1 = 4'h2; sel0 = 3'd0; sel1 = 3'd7;
        n = 0;
        for (int i = 0; i < 8; i++) begin ids[i] = -1; ts[i] = -1; end
        repeat (22) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                if (n < 8) begin ids[n] = int'(ack1); ts[n] = cyc; end
                n++;
            end
        end
        result("rr_ack_count", n >= 4, $sformatf("%0d acks", n), "at least 4");
        for (int i = 0; i < 4; i++) begin
            result("rr_order", ids[i] == i % 2, $sformatf("ack %0d from %0d", i, ids[i]), $sformatf("%0d", i % 2));
            if (i > 0) result("rr_spacing", ts[i] - ts[i-1] == P, $sformatf("%0d", ts[i] - ts[i-1]), $sformatf("%0d", P));
        end

        // late req1 during req0 setup, data0 changes must not leak
        do_reset();
        req0 = 1'b1; data0 = 4'hA; sel0 = 3'd3; c0 = cyc;
        @(negedge clk);
        req1 = 1'b1; data1 = 4'hC; sel1 = 3'd6;
        @(negedge clk);
        data0 = 4'h3;
        t0 = -1; t1 = -1;
        for (int i = 0; i < 20 && t1 < 0; i++) begin
            @(negedge clk);
            data0 = 4'($urandom);
            if (ack0) begin t0 = cyc; req0 = 1'b0; end
            if (ack1) begin
                t1 = cyc;
                result("late_req1_data", select == 3'd6 && input_data == 4'hC,
                       $sformatf("sel %0d data %0h", select, input_data), "sel 6 data c");
                req1 = 1'b0;
            end
        end
        result("late_ack0_cycle", t0 == c0 + 4, $sformatf("%0d", t0), $sformatf("%0d", c0 + 4));
        result("late_ack1_cycle", t1 == c0 + 9, $sformatf("%0d", t1), $sformatf("%0d", c0 + 9));

        // reset during strobe aborts, next request is serviced normally
        do_reset();
        req0 = 1'b1; data0 = 4'h7; sel0 = 3'd5; c0 = cyc;
        repeat (3) @(negedge clk);
        result("abort_strobe_seen", en == 1'b1, $sformatf("%0b", en), "1");
        rst = 1'b0;
        @(negedge clk);
        result("abort_outputs", !en && !ack0 && !busy, $sformatf("en %0b ack0 %0b busy %0b", en, ack0, busy), "all 0");
        rst = 1'b1;
        t0 = -1;
        for (int i = 0; i < 12 && t0 < 0; i++) begin
            @(negedge clk);
            if (ack0) begin
                t0 = cyc;
                result("abort_retry_data", select == 3'd5 && input_data == 4'h7,
                       $sformatf("sel %0d data %0h", select, input_data), "sel 5 data 7");
            end
        end
        result("abort_retry_ack", t0 == c0 + 8, $sformatf("%0d", t0), $sformatf("%0d", c0 + 8));
        req0 = 1'b0;

`ifdef SEG_WR_CLEAR_EN
        // clear takes priority over a pending req1
        do_reset();
        req0 = 1'b1; data0 = 4'h1; sel0 = 3'd1;
        @(negedge clk);
        clr_req = 1'b1; req1 = 1'b1; data1 = 4'h9; sel1 = 3'd4;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0; done_at = -1; got1 = 1'b0;
        for (int i = 0; i < 16; i++) begin es[i] = -1; ed[i] = -1; end
        for (int i = 0; i < 120 && !got1; i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (en) begin
                if (n < 16) begin es[n] = int'(select); ed[n] = int'(input_data); end
                n++;
            end
            if (clr_done) done_at = n;
            if (ack1) begin got1 = 1'b1; req1 = 1'b0; end
        end
        result("clr_strobes", n == 10, $sformatf("%0d", n), "10");
        for (int k = 0; k < 8; k++)
            result("clr_write", es[k+1] == k && ed[k+1] == 0, $sformatf("sel %0d data %0h", es[k+1], ed[k+1]),
                   $sformatf("sel %0d data 0", k));
        result("clr_done_pos", done_at == 9, $sformatf("after %0d strobes", done_at), "after 9 strobes");
        result("clr_then_req1", got1 && es[9] == 4 && ed[9] == 9,
               $sformatf("ack1 %0b sel %0d data %0h", got1, es[9], ed[9]), "ack1 1 sel 4 data 9");
`else
        // clr_req has no effect without the clear sequencer
        do_reset();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0; done_at = 0;
        repeat (60) begin
            @(negedge clk);
            if (en) n++;
            if (clr_done) done_at++;
        end
        result("noclr_en", n == 0, $sformatf("%0d strobes", n), "0 strobes");
        result("noclr_done", done_at == 0, $sformatf("%0d pulses", done_at), "0 pulses");
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0; else if (!req0) req0 = $urandom_range(3) == 0;
            if (ack1) req1 = 1'b0; else if (!req1) req1 = $urandom_range(3) == 0;
            data0   = 4'($urandom);
            data1   = 4'($urandom);
            sel0    = 3'($urandom);
            sel1    = 3'($urandom);
            clr_req = $urandom_range(60) == 0;
            rst     = $urandom_range(400) != 0;
        end
        req0 = 1'b0; req1 = 1'b0; clr_req = 1'b0; rst = 1'b1;
        repeat (120) @(negedge clk);
        result("drain", exp_q.size() == 0, $sformatf("%0d events left", exp_q.size()), "0 events left");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_wr_arbiter.md
SEG_WR_ARBITER -- requirements
Module: seg_wr_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles that input_data/select are stable before en rises (1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 1: cycles en stays high (1..15).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports req0 and req1, input, 1 each: write requests from requester 0 and requester 1.
REQ-006 SHALL have ports data0 and data1, input, 4 each: digit value from each requester.
REQ-007 SHALL have ports sel0 and sel1, input, 3 each: target digit index 0..7 from each requester.
REQ-008 SHALL have ports ack0 and ack1, output, 1 each: one-cycle completion pulse per requester.
REQ-009 SHALL have port clr_req, input, 1: request to clear all eight digits.
REQ-010 SHALL have port clr_done, output, 1: one-cycle pulse when the clear completes.
REQ-011 SHALL have port input_data, output, 4: digit value driven to the 8-digit display core.
REQ-012 SHALL have port select, output, 3: digit index driven to the display core.
REQ-013 SHALL have port en, output, 1: write strobe to the display core.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, and CLR.
REQ-017 In IDLE, on an edge with any request active, the block SHALL latch the winner's data and select and go to SETUP; the requester's inputs are don't-care after that edge.
REQ-018 Arbitration SHALL be round-robin: if req0 and req1 are both high, the grant goes to the requester not granted last; a lone request is always granted.
REQ-019 The last-grant pointer SHALL change only when a grant is issued.
REQ-020 SETUP SHALL last exactly SETUP_CYC cycles with input_data/select at the latched values and en=0.
REQ-021 STROBE SHALL last exactly STROBE_CYC cycles with en=1 and input_data/select unchanged.
REQ-022 HOLD SHALL last 1 cycle with en=0 and data unchanged; the granted ack SHALL be high only during HOLD; the next state is IDLE.
REQ-023 With default parameters, ack SHALL be high in the 4th cycle after the grant edge; back-to-back grants SHALL be spaced SETUP_CYC+STROBE_CYC+2 cycles apart.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle, and en SHALL never be high outside STROBE.
REQ-025 Requests arriving while busy=1 SHALL be neither lost nor latched; a request held high is serviced on a later IDLE.
REQ-026 A requester SHALL hold req until its ack; an ack cycle SHALL NOT retrigger that requester unless its req is still high in the following IDLE.

Reset
REQ-027 When rst=0 at a clock edge: state=IDLE, en=0, select=0, input_data=0, ack0=ack1=0, clr_done=0, busy=0, last-grant=1 (req0 wins the first contention), clear pending and clear counter zeroed.
REQ-028 Reset mid-transaction SHALL abort it without issuing ack or clr_done; en SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-029 With macro SEG_WR_CLEAR_EN defined, a clr_req pulse SHALL set a clear-pending flag, including while busy=1.
REQ-030 With SEG_WR_CLEAR_EN defined, a pending clear SHALL take priority over req0 and req1 in IDLE.
REQ-031 With SEG_WR_CLEAR_EN defined, the clear SHALL write 4'h0 to select 0,1,...,7 in order; each write uses the SETUP/STROBE/HOLD timing with no ack0/ack1; clr_done SHALL pulse in the final HOLD; the pending flag SHALL clear at clear start; last-grant SHALL be unchanged.
REQ-032 Without SEG_WR_CLEAR_EN, clr_req SHALL be ignored, clr_done SHALL be tied to 0, the CLR state SHALL be absent, and the port list SHALL be unchanged.

Verification
REQ-033 Bench SHALL check: after reset, req0=1, data0=4'h5, sel0=3'd2 -> select=2 and input_data=5 for 4 cycles, en high 1 cycle in the 3rd, ack0 in the 4th cycle after grant.
REQ-034 Bench SHALL check: req0 and req1 high continuously after reset -> grants alternate 0,1,0,1; acks spaced 5 cycles; no overlap.
REQ-035 Bench SHALL check: req1 rises while the req0 transfer is in SETUP -> req1 granted in the IDLE after ack0; data1 is unaffected by changes to data0.
REQ-036 Bench SHALL check: rst=0 during STROBE -> en=0 next cycle, no ack, and the next req0 is serviced normally.
REQ-037 Bench SHALL check, with SEG_WR_CLEAR_EN: clr_req pulse while req1 is pending -> eight en strobes with select 0..7 and input_data 0, clr_done on the last, then req1 granted.
REQ-038 Bench SHALL check, without SEG_WR_CLEAR_EN: clr_req pulse -> no en activity and clr_done stays 0.
